tri_query_feeder: RTL

//  Upstream sequencer for the signP point-in-triangle pipeline. Accepts one packed request
//  (triangle V0,V1,V2 plus query point P) over a valid/ready handshake. Serialises it onto

---
 rtl/tri_pkg.sv | 36 +++
 rtl/tri_query_feeder_valid_delay.sv | 36 +++
 rtl/tri_query_feeder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tri_pkg.sv
// Shared types for the signP query feeder: coordinate width, request layout,
// sequencer states and the triangle-compare helper.
package tri_pkg;

  localparam int unsigned W = 11;

  typedef logic [W-1:0] coord_t;

  typedef struct packed {
    coord_t px;
    coord_t py;
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
    coord_t x2;
    coord_t y2;
  } tri_req_t;

  // Vertex-only view of a request; this is what the triangle cache holds.
  typedef logic [6*W-1:0] tri_verts_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V0,
    ST_V1,
    ST_V2,
    ST_PT,
    ST_GAP
  } state_t;

  function automatic tri_verts_t tri_verts(input tri_req_t r);
    return {r.x0, r.y0, r.x1, r.y1, r.x2, r.y2};
  endfunction

endpackage

// File: rtl/tri_query_feeder_valid_delay.sv
// Fixed-latency 1-bit delay line: a pulse entering on pulse_in leaves on
// pulse_out exactly LAT cycles later. Cleared synchronously by reset so a
// query abandoned mid-flight never reports a result.
module valid_delay
#(
  parameter int unsigned LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic pulse_out,
  output logic pending
);

  if (LAT < 1) begin : g_lat_check
    $error("valid_delay: LAT must be at least 1");
  end

  logic [LAT-1:0] sr;

  // Shift register advancing one stage per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= pulse_in;
      for (int unsigned k = 1; k < LAT; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  assign pulse_out = sr[LAT-1];
  assign pending   = |sr;

endmodule

// File: rtl/tri_query_feeder.sv
// Upstream sequencer for the signP point-in-triangle pipeline. Takes one
// packed request (triangle + query point), plays the vertices onto signP's
// re/i1/i2 beat bus (re=0), then holds the point with re=1 for HOLD cycles,
// and flags s_valid when signP's s belongs to that query. An unchanged
// triangle skips the vertex reload when SKIP_SAME is set.
module tri_query_feeder
  import tri_pkg::*;
#(
  parameter int unsigned HOLD      = 3,
  parameter int unsigned LAT       = 3,
  parameter bit          SKIP_SAME = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_px,
  input  logic [W-1:0] in_py,
  input  logic [W-1:0] in_x0,
  input  logic [W-1:0] in_y0,
  input  logic [W-1:0] in_x1,
  input  logic [W-1:0] in_y1,
  input  logic [W-1:0] in_x2,
  input  logic [W-1:0] in_y2,
  output logic         re,
  output logic [W-1:0] i1,
  output logic [W-1:0] i2,
  output logic         s_valid,
  output logic         busy
);

  if (HOLD < 1) begin : g_hold_check
    $error("tri_query_feeder: HOLD must be at least 1");
  end

  localparam int unsigned   CW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  state_t        state, state_nxt;
  tri_req_t      req, req_nxt;
  tri_req_t      in_req;
  tri_verts_t    cache, cache_nxt;
  logic          cache_valid, cache_valid_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          re_nxt, in_ready_nxt;
  logic [W-1:0]  i1_nxt, i2_nxt;
  logic          accept, hit, pt_first, dl_pending;

  assign in_req   = {in_px, in_py, in_x0, in_y0, in_x1, in_y1, in_x2, in_y2};
  assign accept   = in_valid && in_ready && (state == ST_IDLE);
  assign hit      = SKIP_SAME && cache_valid && (cache == tri_verts(in_req));
  assign pt_first = (state == ST_PT) && (cnt == '0);

  // State, request, cache, hold counter and registered beat outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      req         <= '0;
      cache       <= '0;
      cache_valid <= 1'b0;
      cnt         <= '0;
      re          <= 1'b1;
      i1          <= '0;
      i2          <= '0;
      in_ready    <= 1'b0;
    end else begin
      state       <= state_nxt;
      req         <= req_nxt;
      cache       <= cache_nxt;
      cache_valid <= cache_valid_nxt;
      cnt         <= cnt_nxt;
      re          <= re_nxt;
      i1          <= i1_nxt;
      i2          <= i2_nxt;
      in_ready    <= in_ready_nxt;
    end
  end

  // Next-state logic: vertex walk on a miss, straight to the point phase on a hit.
  always_comb begin
    state_nxt       = state;
    req_nxt         = req;
    cache_nxt       = cache;
    cache_valid_nxt = cache_valid;
    cnt_nxt         = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          req_nxt   = in_req;
          cnt_nxt   = '0;
          state_nxt = hit ? ST_PT : ST_V0;
        end
      end
      ST_V0: state_nxt = ST_V1;
      ST_V1: state_nxt = ST_V2;
      ST_V2: begin
        state_nxt       = ST_PT;
        cnt_nxt         = '0;
        cache_nxt       = tri_verts(req);
        cache_valid_nxt = 1'b1;
      end
      ST_PT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Beat outputs are computed from the upcoming state so that the registered
  // re/i1/i2 line up with the cycle the state is occupied; re stays 1 in
  // every state except the three vertex beats.
  always_comb begin
    re_nxt       = 1'b1;
    i1_nxt       = i1;
    i2_nxt       = i2;
    in_ready_nxt = (state_nxt == ST_IDLE);
    case (state_nxt)
      ST_V0: begin
        re_nxt = 1'b0;
        i1_nxt = req_nxt.x0;
        i2_nxt = req_nxt.y0;
      end
      ST_V1: begin
        re_nxt = 1'b0;
        i1_nxt = req_nxt.x1;
        i2_nxt = req_nxt.y1;
      end
      ST_V2: begin
        re_nxt = 1'b0;
        i1_nxt = req_nxt.x2;
        i2_nxt = req_nxt.y2;
      end
      ST_PT: begin
        i1_nxt = req_nxt.px;
        i2_nxt = req_nxt.py;
      end
      default: begin
      end
    endcase
  end

  valid_delay #(
    .LAT(LAT)
  ) u_valid_delay (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pt_first),
    .pulse_out(s_valid),
    .pending  (dl_pending)
  );

  assign busy = (state != ST_IDLE) || dl_pending;

endmodule
